// File: rtl/event_handle_scheduler.sv
// Named-event handle table: maps handles to event objects and turns immediate
// and nonblocking triggers into registered one-cycle fire pulses with counters.
module event_handle_scheduler #(
  parameter  int NUM_HANDLES = 4,
  parameter  int NUM_EVENTS  = 4,
  parameter  int CW          = 8,
  localparam int HW          = $clog2(NUM_HANDLES),
  localparam int EW          = $clog2(NUM_EVENTS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [HW-1:0]            cmd_dst,
  input  logic [HW-1:0]            cmd_src,
  output logic [NUM_EVENTS-1:0]    ev_fire,
  output logic                     null_trig,
  output logic [NUM_EVENTS*CW-1:0] fire_cnt,
  input  logic [HW-1:0]            rd_handle,
  output logic [EW-1:0]            rd_event,
  output logic                     rd_null
);

  // state | meaning
  // INIT  | sweeping the table to default mapping, one entry per cycle
  // RUN   | accepting commands
  typedef enum logic {INIT, RUN} state_t;

  localparam int HS = 1 << HW;
  localparam logic [1:0] OP_TRIG    = 2'd0;
  localparam logic [1:0] OP_TRIG_NB = 2'd1;
  localparam logic [1:0] OP_COPY    = 2'd2;
  localparam logic [1:0] OP_NULLIFY = 2'd3;

  state_t                state, state_next;
  logic [HW-1:0]         sweep_ptr;
  logic [HS-1:0]         tbl_valid;
  logic [EW-1:0]         tbl_ev [HS];
  logic                  accept;
  logic                  dst_valid, src_valid;
  logic [EW-1:0]         dst_ev, src_ev;
  logic [NUM_EVENTS-1:0] imm_set, nb_set, nb_pend, fire_next;
  logic                  null_next;
  logic [CW-1:0]         cnt [NUM_EVENTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      sweep_ptr <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) sweep_ptr <= sweep_ptr + HW'(1);
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    case (state)
      INIT: if (sweep_ptr == HW'(NUM_HANDLES - 1)) state_next = RUN;
      RUN:  cmd_ready = ~rst;
      default: state_next = INIT;
    endcase
  end

  assign accept    = cmd_valid & cmd_ready;
  assign dst_valid = tbl_valid[cmd_dst];
  assign dst_ev    = tbl_ev[cmd_dst];
  assign src_valid = tbl_valid[cmd_src];
  assign src_ev    = tbl_ev[cmd_src];

  // Entries beyond NUM_HANDLES are never written and stay null.
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_valid <= '0;
    end else if (state == INIT) begin
      for (int i = 0; i < NUM_HANDLES; i++) begin
        if (sweep_ptr == HW'(i)) begin
          tbl_valid[i] <= (i < NUM_EVENTS);
          tbl_ev[i]    <= EW'(i);
        end
      end
    end else if (accept) begin
      for (int i = 0; i < NUM_HANDLES; i++) begin
        if (cmd_dst == HW'(i)) begin
          if (cmd_op == OP_COPY) begin
            tbl_valid[i] <= src_valid;
            tbl_ev[i]    <= src_ev;
          end else if (cmd_op == OP_NULLIFY) begin
            tbl_valid[i] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    imm_set   = '0;
    nb_set    = '0;
    null_next = 1'b0;
    if (accept && (cmd_op == OP_TRIG || cmd_op == OP_TRIG_NB)) begin
      if (!dst_valid) begin
        null_next = 1'b1;
      end else begin
        for (int k = 0; k < NUM_EVENTS; k++) begin
          if (dst_ev == EW'(k)) begin
            if (cmd_op == OP_TRIG) imm_set[k] = 1'b1;
            else                   nb_set[k]  = 1'b1;
          end
        end
      end
    end
  end

  // A pending ->> and a same-cycle -> on one event merge into a single pulse.
  assign fire_next = imm_set | nb_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_fire   <= '0;
      null_trig <= 1'b0;
      nb_pend   <= '0;
      for (int k = 0; k < NUM_EVENTS; k++) cnt[k] <= '0;
    end else begin
      ev_fire   <= fire_next;
      null_trig <= null_next;
      nb_pend   <= nb_set;
      for (int k = 0; k < NUM_EVENTS; k++) cnt[k] <= cnt[k] + CW'(fire_next[k]);
    end
  end

  for (genvar k = 0; k < NUM_EVENTS; k++) begin : g_cnt
    assign fire_cnt[k*CW +: CW] = cnt[k];
  end

  assign rd_null  = ~tbl_valid[rd_handle];
  assign rd_event = tbl_valid[rd_handle] ? tbl_ev[rd_handle] : '0;

endmodule

// File: tb/tb_event_handle_scheduler.sv
// Directed bench for event_handle_scheduler: reset/init sweep, triggers,
// handle copy and nulling, coalescing, mid-operation reset and counter wrap.
module tb_event_handle_scheduler;

  localparam logic [1:0] TRIG = 2'd0, TRIG_NB = 2'd1, COPY = 2'd2, NULLIFY = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_dst;
  logic [1:0]  cmd_src;
  logic [3:0]  ev_fire;
  logic        null_trig;
  logic [31:0] fire_cnt;
  logic [1:0]  rd_handle;
  logic [1:0]  rd_event;
  logic        rd_null;

  int checks = 0;
  int errors = 0;
  int exp_cnt [4];

  event_handle_scheduler dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src),
    .ev_fire(ev_fire), .null_trig(null_trig), .fire_cnt(fire_cnt),
    .rd_handle(rd_handle), .rd_event(rd_event), .rd_null(rd_null)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_vec();
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[k*8 +: 8] = exp_cnt[k][7:0];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] src);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dst   = dst;
    cmd_src   = src;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    int rise;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_src = '0; rd_handle = 2'd2;
    for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
    tick(); tick();
    checks++;
    if (cmd_ready !== 1'b0 || ev_fire !== 4'b0 || fire_cnt !== 32'b0 || null_trig !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: ready=%b fire=%b cnt=%h null=%b, want 0 0 0 0", cmd_ready, ev_fire, fire_cnt, null_trig);
    end
    rst = 1'b0;
    rise = -1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 1) begin
        checks++;
        if (rd_null !== 1'b1) begin
          errors++;
          $display("FAIL init_unswept_null: rd_null=%b, want 1", rd_null);
        end
      end
      if (cmd_ready === 1'b1 && rise < 0) rise = n;
      checks++;
      if (ev_fire !== 4'b0 || fire_cnt !== 32'b0) begin
        errors++;
        $display("FAIL idle_quiet cycle %0d: fire=%b cnt=%h, want 0 0", n, ev_fire, fire_cnt);
      end
    end
    checks++;
    if (rise != 4) begin
      errors++;
      $display("FAIL ready_rise: rose after %0d cycles, want 4", rise);
    end
    checks++;
    if (rd_event !== 2'd2 || rd_null !== 1'b0) begin
      errors++;
      $display("FAIL rd_default_h2: event=%0d null=%b, want 2 0", rd_event, rd_null);
    end
  endtask

  task automatic test_trig();
    issue(TRIG, 2'd1, 2'd0);
    exp_cnt[1]++;
    checks++;
    if (ev_fire !== 4'b0010 || fire_cnt !== exp_vec()) begin
      errors++;
      $display("FAIL trig_h1: fire=%b cnt=%h, want 0010 %h", ev_fire, fire_cnt, exp_vec());
    end
    tick();
    checks++;
    if (ev_fire !== 4'b0000) begin
      errors++;
      $display("FAIL trig_h1_one_cycle: fire=%b, want 0000", ev_fire);
    end
  endtask

  task automatic test_copy_alias();
    issue(COPY, 2'd0, 2'd3);
    issue(TRIG, 2'd0, 2'd0);
    exp_cnt[3]++;
    checks++;
    if (ev_fire !== 4'b1000 || fire_cnt !== exp_vec()) begin
      errors++;
      $display("FAIL copy_h0_from_h3: fire=%b cnt=%h, want 1000 %h", ev_fire, fire_cnt, exp_vec());
    end
    rd_handle = 2'd0;
    #1;
    checks++;
    if (rd_event !== 2'd3 || rd_null !== 1'b0) begin
      errors++;
      $display("FAIL rd_h0_after_copy: event=%0d null=%b, want 3 0", rd_event, rd_null);
    end
    issue(TRIG, 2'd2, 2'd0);
    exp_cnt[2]++;
    checks++;
    if (ev_fire !== 4'b0100 || fire_cnt !== exp_vec()) begin
      errors++;
      $display("FAIL trig_h2_only: fire=%b cnt=%h, want 0100 %h", ev_fire, fire_cnt, exp_vec());
    end
    tick();
  endtask

  task automatic test_copy_nb();
    issue(COPY, 2'd3, 2'd2);
    issue(TRIG_NB, 2'd3, 2'd0);
    checks++;
    if (ev_fire !== 4'b0000) begin
      errors++;
      $display("FAIL nb_not_early: fire=%b, want 0000", ev_fire);
    end
    tick();
    exp_cnt[2]++;
    checks++;
    if (ev_fire !== 4'b0100 || fire_cnt !== exp_vec()) begin
      errors++;
      $display("FAIL nb_copy_h3_to_e2: fire=%b cnt=%h, want 0100 %h", ev_fire, fire_cnt, exp_vec());
    end
    tick();
    checks++;
    if (ev_fire !== 4'b0000) begin
      errors++;
      $display("FAIL nb_one_cycle: fire=%b, want 0000", ev_fire);
    end
    rd_handle = 2'd3;
    #1;
    checks++;
    if (rd_event !== 2'd2 || rd_null !== 1'b0) begin
      errors++;
      $display("FAIL rd_h3_after_copy: event=%0d null=%b, want 2 0", rd_event, rd_null);
    end
  endtask

  task automatic test_nullify();
    issue(NULLIFY, 2'd3, 2'd0);
    issue(TRIG, 2'd3, 2'd0);
    checks++;
    if (null_trig !== 1'b1 || ev_fire !== 4'b0000) begin
      errors++;
      $display("FAIL trig_null_h3: null=%b fire=%b, want 1 0000", null_trig, ev_fire);
    end
    rd_handle = 2'd3;
    #1;
    checks++;
    if (rd_null !== 1'b1) begin
      errors++;
      $display("FAIL rd_h3_null: rd_null=%b, want 1", rd_null);
    end
    tick();
    checks++;
    if (null_trig !== 1'b0) begin
      errors++;
      $display("FAIL null_trig_one_cycle: null=%b, want 0", null_trig);
    end
    issue(TRIG_NB, 2'd3, 2'd0);
    checks++;
    if (null_trig !== 1'b1 || ev_fire !== 4'b0000) begin
      errors++;
      $display("FAIL nb_null_h3_t1: null=%b fire=%b, want 1 0000", null_trig, ev_fire);
    end
    tick();
    checks++;
    if (null_trig !== 1'b0 || ev_fire !== 4'b0000 || fire_cnt !== exp_vec()) begin
      errors++;
      $display("FAIL nb_null_h3_t2: null=%b fire=%b cnt=%h, want 0 0000 %h", null_trig, ev_fire, fire_cnt, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    issue(TRIG_NB, 2'd1, 2'd0);
    checks++;
    if (ev_fire !== 4'b0000) begin
      errors++;
      $display("FAIL coalesce_t1: fire=%b, want 0000", ev_fire);
    end
    issue(TRIG, 2'd1, 2'd0);
    exp_cnt[1]++;
    checks++;
    if (ev_fire !== 4'b0010 || fire_cnt !== exp_vec()) begin
      errors++;
      $display("FAIL coalesce_t2: fire=%b cnt=%h, want 0010 %h", ev_fire, fire_cnt, exp_vec());
    end
    tick();
    checks++;
    if (ev_fire !== 4'b0000 || fire_cnt !== exp_vec()) begin
      errors++;
      $display("FAIL coalesce_t3: fire=%b cnt=%h, want 0000 %h", ev_fire, fire_cnt, exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    issue(TRIG_NB, 2'd1, 2'd0);
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_op = TRIG; cmd_dst = 2'd1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_low_in_rst: ready=%b, want 0", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
    checks++;
    if (ev_fire !== 4'b0000 || fire_cnt !== 32'b0) begin
      errors++;
      $display("FAIL rst_mid_clear: fire=%b cnt=%h, want 0000 0", ev_fire, fire_cnt);
    end
    for (int n = 1; n <= 6; n++) begin
      tick();
      checks++;
      if (ev_fire !== 4'b0000 || null_trig !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_quiet cycle %0d: fire=%b null=%b, want 0000 0", n, ev_fire, null_trig);
      end
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_rst_mid: ready=%b, want 1", cmd_ready);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) begin
      issue(TRIG, 2'd0, 2'd0);
      exp_cnt[0] = (exp_cnt[0] + 1) % 256;
      if (i == 254) begin
        checks++;
        if (fire_cnt[7:0] !== 8'd255) begin
          errors++;
          $display("FAIL cnt_255: cnt0=%0d, want 255", fire_cnt[7:0]);
        end
      end
    end
    checks++;
    if (fire_cnt[7:0] !== 8'd0 || ev_fire !== 4'b0001 || fire_cnt !== exp_vec()) begin
      errors++;
      $display("FAIL cnt_wrap: cnt=%h fire=%b, want %h 0001", fire_cnt, ev_fire, exp_vec());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_trig();
    test_copy_alias();
    test_copy_nb();
    test_nullify();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
